// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch queue: FSM states, the NOP used
// for fault entries, and the buffered entry layout.
package fetch_pkg;

  // Entry fields are sized for the 32-bit datapath this block is built for.
  localparam int XLEN = 32;

  // Encoding of ADDI x0, x0, 0; carried by misaligned-fetch fault entries.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    FAULT_PUSH = 2'd1,
    HALTED     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. flush empties the buffer and wins over
// a push or pop in the same cycle. A push while full is accepted only when a
// pop frees the head slot in that same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  // Effective push/pop after flush override and occupancy limits.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch initiator: holds the fetch PC, reads one word per cycle
// from instruction memory while buffer space exists, and hands instructions
// to decode. Handshake: an entry transfers on a rising edge where
// inst_valid_out && inst_ready_in; head outputs hold while valid && !ready.
// A redirect flushes the buffer; a misaligned target yields one fault entry
// and fetch halts until the next redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [WIDTH-3:0]       imem_addr_out,
  input  logic [WIDTH-1:0]       imem_data_in,
  input  logic                   redirect_valid_in,
  input  logic [WIDTH-1:0]       redirect_pc_in,
  output logic                   inst_valid_out,
  input  logic                   inst_ready_in,
  output logic [WIDTH-1:0]       inst_out,
  output logic [WIDTH-1:0]       inst_pc_out,
  output logic                   inst_fault_out,
  output fetch_state_e           state_dbg,
  output logic [$clog2(DEPTH):0] count_dbg
);

  fetch_state_e     state_q;
  fetch_state_e     state_n;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_n;

  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             push;
  logic             pop;
  logic             flush;
  logic             space;
  logic             fifo_full;
  logic             fifo_empty;

  assign inst_valid_out = !fifo_empty;
  assign pop            = inst_valid_out && inst_ready_in;
  assign space          = !fifo_full || pop;

  assign imem_addr_out  = pc_q[WIDTH-1:2];
  assign inst_out       = inst_valid_out ? head.inst  : '0;
  assign inst_pc_out    = inst_valid_out ? head.pc    : '0;
  assign inst_fault_out = inst_valid_out ? head.fault : 1'b0;
  assign state_dbg      = state_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_dbg)
  );

  // State and fetch PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
    end
  end

  // Next state, next PC and push request; redirect overrides everything.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '0;
    case (state_q)
      FETCH: begin
        if (space) begin
          push       = 1'b1;
          push_entry = '{inst: imem_data_in, pc: pc_q, fault: 1'b0};
          pc_n       = pc_q + WIDTH'(4);
        end
      end
      FAULT_PUSH: begin
        // Buffer was just flushed, so this push always has room.
        push       = 1'b1;
        push_entry = '{inst: NOP_INSTR, pc: pc_q, fault: 1'b1};
        state_n    = HALTED;
      end
      HALTED: begin
      end
      default: state_n = FETCH;
    endcase
    if (redirect_valid_in) begin
      flush      = 1'b1;
      push       = 1'b0;
      push_entry = '0;
      pc_n       = redirect_pc_in;
      state_n    = (redirect_pc_in[1:0] == 2'b00) ? FETCH : FAULT_PUSH;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model of the fetch buffer,
// directed scenarios and a randomized run with redirects and a mid-run reset.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  fetch_state_e state_dbg;
  logic [2:0]  count_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered entries {fault, pc, inst}, fetch PC, mode.
  logic [64:0] exp_q[$];
  logic [31:0] m_pc;
  int          m_mode;  // 0 fetching, 1 fault entry pending, 2 halted

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  assign imem_data = mem_word({imem_addr, 2'b00});

  fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr_out     (imem_addr),
    .imem_data_in      (imem_data),
    .redirect_valid_in (redirect_valid),
    .redirect_pc_in    (redirect_pc),
    .inst_valid_out    (inst_valid),
    .inst_ready_in     (inst_ready),
    .inst_out          (inst),
    .inst_pc_out       (inst_pc),
    .inst_fault_out    (inst_fault),
    .state_dbg         (state_dbg),
    .count_dbg         (count_dbg)
  );

  // Expected head as {valid, fault, pc, inst}; all zero when empty.
  function automatic logic [65:0] exp_head();
    if (exp_q.size() == 0) return '0;
    return {1'b1, exp_q[0]};
  endfunction

  function automatic logic [65:0] dut_head();
    return {inst_valid, inst_fault, inst_pc, inst};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc   = RPC;
    m_mode = 0;
  endtask

  // One clock edge of the model given the inputs held during that cycle.
  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    int  sz;
    bit  popped;
    if (rv) begin
      exp_q.delete();
      m_pc   = rpc;
      m_mode = (rpc[1:0] == 2'b00) ? 0 : 1;
      return;
    end
    sz     = exp_q.size();
    popped = (sz > 0) && rdy;
    if (popped) void'(exp_q.pop_front());
    if (m_mode == 0) begin
      if (sz < D || popped) begin
        exp_q.push_back({1'b0, m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end else if (m_mode == 1) begin
      exp_q.push_back({1'b1, m_pc, NOP_INSTR});
      m_mode = 2;
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(redirect_valid, redirect_pc, inst_ready);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++;
    if (dut_head() !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_head: got %h required 0", dut_head());
    end
    n_checks++;
    if (imem_addr !== RPC[31:2]) begin
      n_fail++;
      $display("FAIL reset_addr: got %h required %h", imem_addr, RPC[31:2]);
    end
    n_checks++;
    if (state_dbg !== FETCH || count_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d count %0d required 0/0", state_dbg, count_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL stream_head c%0d: got %h required %h", i, dut_head(), exp_head());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      #1;
      n_checks++;
      if (dut_head() !== exp_head() || imem_addr !== m_pc[31:2] || count_dbg !== 3'(exp_q.size())) begin
        n_fail++;
        $display("FAIL stall c%0d: got %h addr %h cnt %0d required %h addr %h cnt %0d",
                 i, dut_head(), imem_addr, count_dbg, exp_head(), m_pc[31:2], exp_q.size());
      end
      tick();
    end
    n_checks++;
    if (imem_addr !== 30'd4 || inst_pc !== 32'd0 || count_dbg !== 3'd4) begin
      n_fail++;
      $display("FAIL stall_full: got addr %h pc %h cnt %0d required 4/0/4", imem_addr, inst_pc, count_dbg);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL drain_head c%0d: got %h required %h", i, dut_head(), exp_head());
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_bubble: got valid %b required 0", inst_valid);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL redirect_head c%0d: got %h required %h", i, dut_head(), exp_head());
      end
      tick();
    end
  endtask

  task automatic test_fault();
    drive(1'b1, 32'h42, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    tick();
    #1;
    n_checks++;
    if (dut_head() !== {1'b1, 1'b1, 32'h42, 32'h13}) begin
      n_fail++;
      $display("FAIL fault_entry: got %h required %h", dut_head(), {1'b1, 1'b1, 32'h42, 32'h13});
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head() || imem_addr !== m_pc[31:2]) begin
        n_fail++;
        $display("FAIL halted c%0d: got %h addr %h required %h addr %h",
                 i, dut_head(), imem_addr, exp_head(), m_pc[31:2]);
      end
      tick();
    end
    drive(1'b1, 32'h80, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL resume c%0d: got %h required %h", i, dut_head(), exp_head());
      end
      tick();
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head() || count_dbg !== 3'(exp_q.size())) begin
        n_fail++;
        $display("FAIL full_pushpop c%0d: got %h cnt %0d required %h cnt %0d",
                 i, dut_head(), count_dbg, exp_head(), exp_q.size());
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (dut_head() !== exp_head() || imem_addr !== m_pc[31:2]) begin
        n_fail++;
        $display("FAIL wrap c%0d: got %h addr %h required %h addr %h",
                 i, dut_head(), imem_addr, exp_head(), m_pc[31:2]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_head() !== 66'h0 || imem_addr !== RPC[31:2]) begin
          n_fail++;
          $display("FAIL async_reset: got %h addr %h required 0 addr %h", dut_head(), imem_addr, RPC[31:2]);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        continue;
      end
      rv  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      drive(rv, rpc, rdy);
      #1;
      n_checks++;
      if (dut_head() !== exp_head() || imem_addr !== m_pc[31:2] || count_dbg !== 3'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random c%0d: got %h addr %h cnt %0d required %h addr %h cnt %0d",
                 i, dut_head(), imem_addr, count_dbg, exp_head(), m_pc[31:2], exp_q.size());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_full_pushpop();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
